// File: rtl/mem_pkg.sv
// Shared constants, word type and address decode helper for the data memory.
package mem_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DEPTH_WORDS = 1024;

  typedef logic [DATA_W-1:0] word_t;

  // Byte address to word index; the two low bits select a byte within the word.
  function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] address);
    return address[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: combinational gated read, synchronous write,
// synchronous clear of the whole array, and an address error flag.
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = mem_pkg::DATA_W,
  parameter int unsigned ADDR_W      = mem_pkg::ADDR_W,
  parameter int unsigned DEPTH_WORDS = mem_pkg::DEPTH_WORDS,
  parameter string       INIT_FILE   = ""
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] Writedata,
  input  logic              clk,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  input  logic              rst,
  output logic              addr_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] DepthIdx = IDX_W'(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] widx;
  logic             in_range;
  logic             misaligned;

  // Start from a known image so nothing reads X before the first reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
      mem[i] = '0;
    end
  end

  assign widx       = address[ADDR_W-1:2];
  assign in_range   = (widx < DepthIdx);
  assign misaligned = (address[1:0] != 2'b00);

  assign addr_err = (memread | memwrite) & (misaligned | ~in_range);

  always_comb begin
    readdata = '0;
    if (memread && in_range) begin
      readdata = mem[widx[AW-1:0]];
    end
  end

  // Reset wins over a same-cycle write; out-of-range writes never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (memwrite && in_range) begin
      mem[widx[AW-1:0]] <= Writedata;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Randomised self-checking bench for data_mem against a plain array model,
// plus directed scenarios with literal expectations.
module tb_data_mem;

  logic [31:0] address;
  logic [31:0] Writedata;
  logic        clk;
  logic        memread;
  logic        memwrite;
  logic [31:0] readdata;
  logic        rst;
  logic        addr_err;

  int checks = 0;
  int passed = 0;

  logic [31:0] model [1024];

  data_mem dut (
    .address  (address),
    .Writedata(Writedata),
    .clk      (clk),
    .memread  (memread),
    .memwrite (memwrite),
    .readdata (readdata),
    .rst      (rst),
    .addr_err (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic rd, input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (rd && idx < 32'd1024) return model[idx[9:0]];
    return 32'h0;
  endfunction

  function automatic logic exp_err(input logic rd, input logic wr, input logic [31:0] a);
    return (rd | wr) && ((a % 4) != 0 || (a / 4) >= 1024);
  endfunction

  // Model: reset clears everything, otherwise an in-range write stores a word.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) model[i] <= 32'h0;
    end else if (memwrite && (address / 4) < 1024) begin
      model[address / 4] <= Writedata;
    end
  end

  always @(negedge clk) begin
    chk("readdata", readdata, exp_rd(memread, address));
    chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err(memread, memwrite, address)});
  end

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    rst       = r;
    memread   = rd;
    memwrite  = wr;
    address   = a;
    Writedata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    chk("init_zero", readdata, 32'h0);
    tick();

    // Reset discards a same-cycle write.
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("pre_reset", readdata, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("reset_clear", readdata, 32'h0);
    tick();

    // Basic write then read, and read gating.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0015);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h4, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_0", readdata, 32'h0000_0015);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("rd_4", readdata, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("rd_gated", readdata, 32'h0);
    tick();

    // Misaligned write lands on the aligned word.
    drive(1'b0, 1'b0, 1'b1, 32'h9, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("mis_err", {31'b0, addr_err}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("mis_rd", readdata, 32'hA5A5_A5A5);
    chk("mis_rd_err", {31'b0, addr_err}, 32'h0);
    tick();

    // Out-of-range write is dropped without wrapping onto word 0.
    drive(1'b0, 1'b0, 1'b1, 32'h1000, 32'h1111_1111);
    @(negedge clk);
    chk("oob_err", {31'b0, addr_err}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    @(negedge clk);
    chk("oob_rd", readdata, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("oob_nowrap", readdata, 32'h0000_0015);
    tick();

    // Same-cycle read and write of one word.
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h2);
    @(negedge clk);
    chk("rw_before", readdata, 32'h1);
    tick();
    chk("rw_after", readdata, 32'h2);

    // Idle cycles leave memory and outputs quiet.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rd", readdata, 32'h0);
      chk("idle_err", {31'b0, addr_err}, 32'h0);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("idle_keep", readdata, 32'hCAFE_F00D);
    tick();

    // Top word boundary.
    drive(1'b0, 1'b0, 1'b1, 32'hFFC, 32'h7777_0001);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'hFFC, 32'h0);
    @(negedge clk);
    chk("top_word", readdata, 32'h7777_0001);
    tick();

    // Randomised traffic checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + ($urandom_range(0, 255) << 2);
        1:       a = $urandom;
        2:       a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
        3:       a = 32'hFFC;
        default: a = $urandom_range(0, 63) << 2;
      endcase
      drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, a, $urandom);
      tick();
    end

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'hFFC, 32'h0);
    @(negedge clk);
    chk("final_reset", readdata, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
